// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing definitions:
//   - default 640x480@60 vertical and horizontal phase lengths
//   - vertical phase encoding (2 bits)
//   - v_total() helper that sums the four vertical phase lengths
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Vertical defaults (lines)
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Horizontal defaults (pixels)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // Row / phase counter width; frame height is limited to 2**ROW_W lines
    localparam int ROW_W = 10;

    typedef enum logic [1:0] {
        VPH_ACTIVE = 2'd0,
        VPH_FRONT  = 2'd1,
        VPH_SYNC   = 2'd2,
        VPH_BACK   = 2'd3
    } vphase_e;

    function automatic int v_total(input int act, input int fp, input int syn, input int bp);
        return act + fp + syn + bp;
    endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// ---------------------------------------------------------------------------
// vga_mod_counter
// Modulo counter with enable, synchronous clear and terminal-count flag.
// The terminal value is either the elaboration-time constant N-1
// (USE_LIMIT=0) or the runtime input limit_i (USE_LIMIT=1).
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous clear, active-low
//   en_i     advance by one (wrapping to 0 after the terminal value)
//   clr_i    synchronous clear to 0, overrides en_i
//   limit_i  runtime terminal value (used only when USE_LIMIT=1)
//   count_o  current count (registered)
//   tc_o     high while count_o is at (or beyond) the terminal value
// ---------------------------------------------------------------------------
module vga_mod_counter #(
    parameter int WIDTH     = 10,
    parameter int N         = 1024,
    parameter bit USE_LIMIT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] last_val;

    assign last_val = USE_LIMIT ? limit_i : WIDTH'(N - 1);

    // ">=" rather than "==" so a count that somehow lands past the limit
    // (e.g. the limit shrank under it) still wraps on the next enable.
    assign tc_o    = (count_q >= last_val);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_vtiming_gen.sv
// ---------------------------------------------------------------------------
// vga_vtiming_gen
// Vertical timing stage. Each cycle LineTick is high counts one line; the
// block walks ACTIVE -> FRONT -> SYNC -> BACK and produces registered
// vertical sync, active qualifier, row index and a frame-start pulse.
//
// Ports:
//   CLK         pixel clock, rising edge
//   Reset_n     asynchronous reset, active-low
//   LineTick    end-of-line strobe from the horizontal timing
//   VSync       vertical sync, at SYNC_POL during the SYNC phase
//   VActive     high during visible lines
//   Row         line index in frame, 0..V_TOTAL-1
//   FrameStart  one-cycle pulse in the cycle Row returns to 0
// ---------------------------------------------------------------------------
module vga_vtiming_gen
    import vga_timing_pkg::*;
#(
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             LineTick,
    output logic             VSync,
    output logic             VActive,
    output logic [ROW_W-1:0] Row,
    output logic             FrameStart
);

    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (V_TOTAL > (1 << ROW_W) || V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_cfg
            $error("vga_vtiming_gen: every phase must be >= 1 line and the frame <= 1024 lines");
        end
    endgenerate

    vphase_e          state_q;
    vphase_e          state_d;
    logic [ROW_W-1:0] phase_limit;
    logic [ROW_W-1:0] phase_cnt;
    logic             phase_tc;
    logic             row_tc;
    logic             recover;
    logic             vsync_q;
    logic             vsync_d;
    logic             vactive_q;
    logic             vactive_d;
    logic             frame_start_q;
    logic             frame_start_d;

    // Terminal value of the phase counter for the phase currently running
    always_comb begin
        phase_limit = '0;
        case (state_q)
            VPH_ACTIVE: phase_limit = ROW_W'(V_ACTIVE - 1);
            VPH_FRONT:  phase_limit = ROW_W'(V_FP - 1);
            VPH_SYNC:   phase_limit = ROW_W'(V_SYNC - 1);
            VPH_BACK:   phase_limit = ROW_W'(V_BP - 1);
            default:    phase_limit = '0;
        endcase
    end

    vga_mod_counter #(
        .WIDTH     (ROW_W),
        .N         (1 << ROW_W),
        .USE_LIMIT (1'b1)
    ) u_phase_cnt (
        .clk_i   (CLK),
        .rst_ni  (Reset_n),
        .en_i    (LineTick),
        .clr_i   (recover),
        .limit_i (phase_limit),
        .count_o (phase_cnt),
        .tc_o    (phase_tc)
    );

    vga_mod_counter #(
        .WIDTH     (ROW_W),
        .N         (V_TOTAL),
        .USE_LIMIT (1'b0)
    ) u_row_cnt (
        .clk_i   (CLK),
        .rst_ni  (Reset_n),
        .en_i    (LineTick),
        .clr_i   (recover),
        .limit_i ('0),
        .count_o (Row),
        .tc_o    (row_tc)
    );

    // Phase count and row wrap are implied by the state walk; kept for debug.
    logic unused_ok;
    assign unused_ok = ^{phase_cnt, row_tc};

    // Next-state and registered-output decode
    always_comb begin
        state_d       = state_q;
        recover       = 1'b0;
        frame_start_d = 1'b0;
        if (LineTick) begin
            case (state_q)
                VPH_ACTIVE: if (phase_tc) state_d = VPH_FRONT;
                VPH_FRONT:  if (phase_tc) state_d = VPH_SYNC;
                VPH_SYNC:   if (phase_tc) state_d = VPH_BACK;
                VPH_BACK: begin
                    if (phase_tc) begin
                        state_d       = VPH_ACTIVE;
                        frame_start_d = 1'b1;
                    end
                end
                default: begin
                    // Corrupted state: restart the frame from row 0
                    state_d = VPH_ACTIVE;
                    recover = 1'b1;
                end
            endcase
        end
        vactive_d = (state_d == VPH_ACTIVE);
        vsync_d   = (state_d == VPH_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= VPH_ACTIVE;
            vactive_q     <= 1'b1;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vactive_q     <= vactive_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign VActive    = vactive_q;
    assign VSync      = vsync_q;
    assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_vtiming_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_vtiming_gen
// Drives the default 640x480 configuration and a tiny 4/1/1/2 configuration
// side by side. Each step pushes the expected outputs (from a row-threshold
// model) onto a scoreboard queue and pops/compares after the clock edge.
// ---------------------------------------------------------------------------
module tb_vga_vtiming_gen;

    localparam int D_TOTAL = 525;
    localparam int S_TOTAL = 8;

    logic       clk;
    logic       Reset_n;
    logic       LineTick;
    logic       LineTick_s;
    logic       VSync, VActive, FrameStart;
    logic [9:0] Row;
    logic       VSync_s, VActive_s, FrameStart_s;
    logic [9:0] Row_s;

    vga_vtiming_gen u_dut (
        .CLK        (clk),
        .Reset_n    (Reset_n),
        .LineTick   (LineTick),
        .VSync      (VSync),
        .VActive    (VActive),
        .Row        (Row),
        .FrameStart (FrameStart)
    );

    vga_vtiming_gen #(
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (2),
        .SYNC_POL (1'b0)
    ) u_dut_s (
        .CLK        (clk),
        .Reset_n    (Reset_n),
        .LineTick   (LineTick_s),
        .VSync      (VSync_s),
        .VActive    (VActive_s),
        .Row        (Row_s),
        .FrameStart (FrameStart_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] row;
        logic       va;
        logic       vs;
        logic       fs;
        logic [9:0] row_s;
        logic       va_s;
        logic       vs_s;
        logic       fs_s;
    } exp_t;

    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    int m_row   = 0;
    int m_row_s = 0;

    // Tick counting between observed FrameStart pulses
    int ticks_d = 0;
    int ticks_s = 0;
    bit have_fs_d = 0;
    bit have_fs_s = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (row=%0d t=%0t)", tag, got, exp, Row, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, predict, check after the rising edge
    task automatic step(input bit rn, input bit lt, input bit lts);
        exp_t e;
        exp_t o;
        @(negedge clk);
        Reset_n    = rn;
        LineTick   = lt;
        LineTick_s = lts;
        if (rn && lt) begin
            m_row = (m_row + 1) % D_TOTAL;
            ticks_d++;
        end
        if (rn && lts) begin
            m_row_s = (m_row_s + 1) % S_TOTAL;
            ticks_s++;
        end
        e.row   = 10'(m_row);
        e.va    = (m_row < 480);
        e.vs    = !(m_row >= 490 && m_row <= 491);
        e.fs    = rn && lt && (m_row == 0);
        e.row_s = 10'(m_row_s);
        e.va_s  = (m_row_s < 4);
        e.vs_s  = (m_row_s != 5);
        e.fs_s  = rn && lts && (m_row_s == 0);
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            o = sb_q.pop_front();
            chk("row",       Row,          o.row);
            chk("vactive",   VActive,      o.va);
            chk("vsync",     VSync,        o.vs);
            chk("framestart",FrameStart,   o.fs);
            chk("row_s",     Row_s,        o.row_s);
            chk("vactive_s", VActive_s,    o.va_s);
            chk("vsync_s",   VSync_s,      o.vs_s);
            chk("fs_s",      FrameStart_s, o.fs_s);
        end
        if (FrameStart) begin
            if (have_fs_d) chk("frame_len", ticks_d, D_TOTAL);
            ticks_d   = 0;
            have_fs_d = 1;
            $display("frame start (default) at t=%0t", $time);
        end
        if (FrameStart_s) begin
            if (have_fs_s) chk("frame_len_s", ticks_s, S_TOTAL);
            ticks_s   = 0;
            have_fs_s = 1;
        end
    endtask

    initial begin
        Reset_n    = 1'b0;
        LineTick   = 1'b0;
        LineTick_s = 1'b0;

        // Ticks while held in reset must not move anything
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        $display("reset: row=%0d vact=%0d vsync=%0d fs=%0d", Row, VActive, VSync, FrameStart);

        // Release: outputs hold until the first tick
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        $display("released idle: row=%0d vact=%0d vsync=%0d", Row, VActive, VSync);

        // First 480 lines; the small instance ticks back-to-back throughout
        for (int i = 0; i < 480; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (m_row == 479 || m_row == 480)
                $display("row=%0d vact=%0d vsync=%0d", Row, VActive, VSync);
        end

        // Sparse ticks through the porch and sync lines
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            if (m_row >= 489 && m_row <= 492 && LineTick)
                $display("row=%0d vsync=%0d", Row, VSync);
        end

        // Three or more complete frames of continuous ticks
        for (int i = 0; i < 3 * D_TOTAL + 40; i++) step(1'b1, 1'b1, 1'b1);
        $display("continuous frames done: row=%0d", Row);

        // Run to row 300, then drop reset between clock edges
        for (int i = 0; i < 600 && m_row != 300; i++) step(1'b1, 1'b1, 1'b1);
        chk("pre_reset_row", Row, 300);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_row",    Row,        0);
        chk("async_vact",   VActive,    1);
        chk("async_vsync",  VSync,      1);
        chk("async_fs",     FrameStart, 0);
        chk("async_row_s",  Row_s,      0);
        $display("async reset: row=%0d vact=%0d vsync=%0d", Row, VActive, VSync);
        m_row     = 0;
        m_row_s   = 0;
        ticks_d   = 0;
        ticks_s   = 0;
        have_fs_d = 0;
        have_fs_s = 0;
        step(1'b0, 1'b1, 1'b1);

        // Next frame after reset runs the full 525 lines, then wraps with a pulse
        for (int i = 0; i < D_TOTAL + 5; i++) step(1'b1, 1'b1, 1'b1);
        $display("post-reset frame: row=%0d", Row);

        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
